// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging N_IN valid/ready streams into one registered output stage.
// Optional macro STREAM_RR_ARBITER_PKT_LOCK_EN holds the grant on one stream until its in_last beat.
module stream_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN-1:0]       in_last,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Handshake: a beat moves on any port when valid and ready are both high at
    // the rising edge; in_ready is the registered-stage-free flag steered to the grant.

    logic [SEL_W-1:0] r_last_grant;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    logic             w_free;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_sel;
    logic [SEL_W-1:0] w_sel;
    logic             w_gnt_vld;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;
    logic             w_locked;

    assign w_free = !r_out_valid || out_ready;

    // Search starts one past the last accepted stream and wraps through it last.
    always_comb begin
        logic [SEL_W-1:0] v_idx;
        w_rr_found = 1'b0;
        w_rr_sel   = '0;
        v_idx      = '0;
        for (int k = 1; k <= N_IN; k++) begin
            v_idx = SEL_W'((int'(r_last_grant) + k) % N_IN);
            if (!w_rr_found && in_valid[v_idx]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = v_idx;
            end
        end
    end

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_lock_sel;

    assign w_locked  = (r_state == ST_LOCK);
    assign w_sel     = w_locked ? r_lock_sel : w_rr_sel;
    assign w_gnt_vld = w_locked ? 1'b1 : w_rr_found;

    // Lock opens on a non-last beat and closes on the locked stream's last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_lock_sel <= '0;
        end else if (w_accept) begin
            case (r_state)
                ST_ARB: begin
                    if (!w_sel_last) begin
                        r_state    <= ST_LOCK;
                        r_lock_sel <= w_sel;
                    end
                end
                ST_LOCK: begin
                    if (w_sel_last) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end
`else
    assign w_locked  = 1'b0;
    assign w_sel     = w_rr_sel;
    assign w_gnt_vld = w_rr_found;
`endif

    assign w_sel_data = in_data[int'(w_sel)*WIDTH +: WIDTH];
    assign w_sel_last = in_last[w_sel];
    assign w_accept   = !rst && w_free && w_gnt_vld && in_valid[w_sel];

    always_comb begin
        in_ready = '0;
        if (!rst && w_free && w_gnt_vld) begin
            in_ready = N_IN'(1) << w_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= SEL_W'(N_IN - 1);
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_sel    <= '0;
            r_out_valid  <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_sel;
            r_out_data   <= w_sel_data;
            r_out_last   <= w_sel_last;
            r_out_sel    <= w_sel;
            r_out_valid  <= 1'b1;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
